// File: rtl/packet_builder_pkg.sv
// packet_builder_pkg
//   Shared constants, the frame state enum and small helpers for the
//   packet builder. The frame is SOF, CMD_H, CMD_L, LEN_H, LEN_L,
//   payload bytes, checksum and EOF.
package packet_builder_pkg;

  localparam int COMMAND_WIDTH = 16;
  localparam int LENGTH_WIDTH  = 16;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] EOF_BYTE = 8'h5A;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SOF     = 4'd1,
    CMD_H   = 4'd2,
    CMD_L   = 4'd3,
    LEN_H   = 4'd4,
    LEN_L   = 4'd5,
    PAYLOAD = 4'd6,
    CSUM    = 4'd7,
    EOF     = 4'd8,
    GUARD   = 4'd9,
    DONE    = 4'd10
  } state_t;

  // Running XOR checksum over the issued header and payload bytes.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // State entered once the guard cycle after a byte issued in state s ends.
  // remaining is the payload count left after that byte was issued.
  function automatic state_t state_after(input state_t s,
                                         input logic [LENGTH_WIDTH-1:0] remaining);
    state_t nxt;
    case (s)
      SOF:     nxt = CMD_H;
      CMD_H:   nxt = CMD_L;
      CMD_L:   nxt = LEN_H;
      LEN_H:   nxt = LEN_L;
      LEN_L:   nxt = (remaining != 16'd0) ? PAYLOAD : CSUM;
      PAYLOAD: nxt = (remaining != 16'd0) ? PAYLOAD : CSUM;
      CSUM:    nxt = EOF;
      EOF:     nxt = DONE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/packet_builder_if.sv
// packet_builder_if
//   Byte-stream bundle around the packet builder.
//   payload_data/payload_valid/payload_ready : filter byte stream into the builder
//   UART_data/UART_is_new/UART_ready         : byte handoff to the UART transmitter
//   master : the builder's view; slave : the surrounding environment's view.
interface packet_builder_if;
  logic [7:0] payload_data;
  logic       payload_valid;
  logic       payload_ready;
  logic [7:0] UART_data;
  logic       UART_is_new;
  logic       UART_ready;

  modport master (
    input  payload_data, payload_valid, UART_ready,
    output payload_ready, UART_data, UART_is_new
  );

  modport slave (
    output payload_data, payload_valid, UART_ready,
    input  payload_ready, UART_data, UART_is_new
  );
endinterface

// File: rtl/packet_builder.sv
// packet_builder
//   Frames a payload byte stream into SOF, command (2 bytes, MSB first),
//   length (2 bytes, MSB first), payload, XOR checksum, EOF, and hands the
//   bytes one at a time to the UART transmitter.
// Ports:
//   clk     : system clock
//   rst     : asynchronous reset, active low
//   start   : one-cycle frame request, only honoured in IDLE
//   command : command echoed in the header, latched on accepted start
//   length  : payload byte count, latched on accepted start
//   bus     : payload stream in, UART byte handoff out (master view)
//   busy    : frame in progress
//   done    : one-cycle pulse once EOF has been handed to the UART
module packet_builder
  import packet_builder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COMMAND_WIDTH-1:0] command,
  input  logic [LENGTH_WIDTH-1:0]  length,
  packet_builder_if.master         bus,
  output logic                     busy,
  output logic                     done
);

  state_t                    state_r;
  state_t                    after_guard_r;
  logic [COMMAND_WIDTH-1:0]  cmd_r;
  logic [LENGTH_WIDTH-1:0]   remaining_r;
  logic [7:0]                csum_r;
  logic [7:0]                uart_data_r;
  logic                      uart_is_new_r;
  logic                      busy_r;
  logic                      done_r;

  logic [7:0]                byte_s;
  logic                      csum_en_s;
  logic                      issue_s;
  logic [LENGTH_WIDTH-1:0]   rem_after_s;

  assign bus.UART_data     = uart_data_r;
  assign bus.UART_is_new   = uart_is_new_r;
  assign busy              = busy_r;
  assign done              = done_r;
  // GUARD is its own state, so being in PAYLOAD already implies no guard pending.
  assign bus.payload_ready = (state_r == PAYLOAD) && bus.UART_ready;

  // Byte selection and issue condition for the current byte state.
  always_comb begin
    byte_s    = 8'h00;
    csum_en_s = 1'b0;
    issue_s   = 1'b0;
    case (state_r)
      SOF:     begin byte_s = SOF_BYTE;     issue_s = bus.UART_ready; end
      CMD_H:   begin byte_s = cmd_r[15:8];  csum_en_s = 1'b1; issue_s = bus.UART_ready; end
      CMD_L:   begin byte_s = cmd_r[7:0];   csum_en_s = 1'b1; issue_s = bus.UART_ready; end
      LEN_H:   begin byte_s = remaining_r[15:8]; csum_en_s = 1'b1; issue_s = bus.UART_ready; end
      LEN_L:   begin byte_s = remaining_r[7:0];  csum_en_s = 1'b1; issue_s = bus.UART_ready; end
      PAYLOAD: begin
        byte_s    = bus.payload_data;
        csum_en_s = 1'b1;
        issue_s   = bus.UART_ready && bus.payload_valid;
      end
      CSUM:    begin byte_s = csum_r;       issue_s = bus.UART_ready; end
      EOF:     begin byte_s = EOF_BYTE;     issue_s = bus.UART_ready; end
      default: begin byte_s = 8'h00; end
    endcase
  end

  // Payload count left once the byte now being issued is accounted for.
  always_comb begin
    if (state_r == PAYLOAD) begin
      rem_after_s = remaining_r - 16'd1;
    end else begin
      rem_after_s = remaining_r;
    end
  end

  // Frame FSM: latch on start, issue one byte per state, guard, then advance.
  // remaining_r holds the latched length through the header, so LEN_H/LEN_L
  // read it directly before the payload starts counting it down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      after_guard_r <= IDLE;
      cmd_r         <= 16'h0000;
      remaining_r   <= 16'h0000;
      csum_r        <= 8'h00;
      uart_data_r   <= 8'h00;
      uart_is_new_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      uart_is_new_r <= 1'b0;
      done_r        <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            cmd_r       <= command;
            remaining_r <= length;
            csum_r      <= 8'h00;
            busy_r      <= 1'b1;
            state_r     <= SOF;
          end
        end
        // The transmitter needs this cycle to drop UART_ready after is_new.
        GUARD: begin
          state_r <= after_guard_r;
          if (after_guard_r == DONE) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          if (issue_s) begin
            uart_data_r   <= byte_s;
            uart_is_new_r <= 1'b1;
            if (csum_en_s) begin
              csum_r <= csum_fold(csum_r, byte_s);
            end
            remaining_r   <= rem_after_s;
            after_guard_r <= state_after(state_r, rem_after_s);
            state_r       <= GUARD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_builder.sv
// tb_packet_builder
//   Randomised bench for packet_builder. A behavioural UART model and payload
//   source run on the falling edge; each frame is predicted as a byte list
//   from command, length and payload and compared with what the UART received.
module tb_packet_builder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] command;
  logic [15:0] length;
  logic        busy;
  logic        done;

  packet_builder_if bus();

  packet_builder dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .command (command),
    .length  (length),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int  pay_len   = 0;
  int  pay_idx   = 0;
  int  valid_pct = 100;
  int  hold      = 0;
  int  ucnt      = 0;
  int  env_h     = 0;
  bit  acc_pend  = 1'b0;
  bit  prev_new  = 1'b0;
  int  dup_cnt   = 0;
  int  done_cnt  = 0;
  int  busy_bad  = 0;
  int  pr_cnt    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Environment: UART transmitter model, payload source and output monitors.
  initial begin
    forever begin
      @(negedge clk);
      if (acc_pend) pay_idx++;
      if (bus.UART_is_new) begin
        if (!bus.UART_ready || prev_new) dup_cnt++;
        rx_q.push_back(bus.UART_data);
        env_h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        if (env_h > 0) begin
          bus.UART_ready = 1'b0;
          ucnt = env_h;
        end
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) bus.UART_ready = 1'b1;
      end
      prev_new = bus.UART_is_new;
      if (done) begin
        done_cnt++;
        if (busy) busy_bad++;
      end
      if (pay_idx < pay_len && int'($urandom_range(0, 99)) < valid_pct) begin
        bus.payload_valid = 1'b1;
        bus.payload_data  = pay_q[pay_idx];
      end else begin
        bus.payload_valid = 1'b0;
        bus.payload_data  = 8'($urandom);
      end
      #2;
      acc_pend = bus.payload_valid && bus.payload_ready;
      if (bus.payload_ready) pr_cnt++;
    end
  end

  // Build the expected frame, reset the environment and issue start.
  task automatic begin_frame(input logic [15:0] cmd, input int len, input int hold_i,
                             input int vpct, input bit fixed);
    logic [7:0] x;
    pay_q.delete();
    for (int i = 0; i < len; i++)
      pay_q.push_back(fixed ? 8'((i + 1) * 10) : 8'($urandom_range(0, 255)));
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(cmd[15:8]);
    exp_q.push_back(cmd[7:0]);
    exp_q.push_back(8'(len >> 8));
    exp_q.push_back(8'(len));
    x = 8'h00;
    for (int i = 1; i < 5; i++) x = x ^ exp_q[i];
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay_q[i]);
      x = x ^ pay_q[i];
    end
    exp_q.push_back(x);
    exp_q.push_back(8'h5A);
    rx_q.delete();
    pay_len = len; pay_idx = 0; acc_pend = 1'b0;
    valid_pct = vpct; hold = hold_i; ucnt = 0;
    bus.UART_ready = 1'b1;
    dup_cnt = 0; done_cnt = 0; busy_bad = 0; pr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; command = cmd; length = 16'(len);
    @(posedge clk); #1;
    start = 1'b0; command = 16'($urandom); length = 16'($urandom);
    check_val("busy_after_start", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_val("sof_latency_is_new", 32'(bus.UART_is_new), 32'd1);
    check_val("sof_latency_data", 32'(bus.UART_data), 32'hA5);
  endtask

  // Wait for done (bounded), optionally re-pulse start, then compare the frame.
  task automatic finish_frame(input bit repulse);
    int cyc = 0;
    int budget = (pay_len + 7) * ((hold < 0 ? 3 : hold) + 4) + pay_len * 40 + 200;
    while (done_cnt == 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start = (repulse && cyc == 10) ? 1'b1 : 1'b0;
      if (repulse && done) begin
        start = 1'b1; command = 16'h1234; length = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_val("done_pulses", 32'(done_cnt), 32'd1);
    check_val("busy_low_with_done", 32'(busy_bad), 32'd0);
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("dup_is_new", 32'(dup_cnt), 32'd0);
    check_val("frame_size", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check_val($sformatf("byte%0d", i),
                (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    if (pay_len == 0) check_val("pready_len0", 32'(pr_cnt), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; command = 16'h0000; length = 16'h0000;
    bus.UART_ready = 1'b1; bus.payload_valid = 1'b0; bus.payload_data = 8'h00;
    #12;
    check_val("rst_uart_data", 32'(bus.UART_data), 32'd0);
    check_val("rst_is_new", 32'(bus.UART_is_new), 32'd0);
    check_val("rst_pready", 32'(bus.payload_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);

    // Payload 10,20,30: header and payload XOR to 8'h00 for this frame.
    begin_frame(16'h0102, 3, 0, 100, 1'b1);
    finish_frame(1'b0);
    // Empty payload goes straight from LEN_L to CSUM.
    begin_frame(16'hFFFF, 0, 0, 100, 1'b0);
    finish_frame(1'b0);
    // Slow transmitter: ready held low 100 cycles after each byte.
    begin_frame(16'hBEEF, 2, 100, 100, 1'b0);
    finish_frame(1'b0);
    // Bursty payload source with random UART pacing.
    begin_frame(16'h7E81, 64, -1, 50, 1'b0);
    finish_frame(1'b0);
    // start re-pulsed while busy and during the DONE cycle.
    begin_frame(16'h4242, 4, 0, 100, 1'b0);
    finish_frame(1'b1);

    // Reset in the middle of the payload.
    begin_frame(16'hC0DE, 10, 0, 100, 1'b0);
    cyc = 0;
    while (pay_idx < 5 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("reach_payload5", 32'(pay_idx >= 5), 32'd1);
    #2; rst = 1'b0;
    pay_len = 0; pay_idx = 0; acc_pend = 1'b0; ucnt = 0; bus.UART_ready = 1'b1;
    #1;
    check_val("abort_uart_data", 32'(bus.UART_data), 32'd0);
    check_val("abort_is_new", 32'(bus.UART_is_new), 32'd0);
    check_val("abort_pready", 32'(bus.payload_ready), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    begin_frame(16'hC0DE, 10, 0, 100, 1'b0);
    finish_frame(1'b0);

    // A few fully random frames.
    for (int f = 0; f < 3; f++) begin
      begin_frame(16'($urandom), int'($urandom_range(0, 20)), -1, 70, 1'b0);
      finish_frame(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
